// File: rtl/ysyx_22040895_mdc.sv
// ysyx_22040895_mdc - iterative multiply/divide controller for the RV64 EXU.
// Runs one M-extension op at a time: radix-2 shift-add multiply or restoring
// divide on operand magnitudes, with a result-sign fix-up on the last step.
// Trivial cases (divide by zero, signed overflow, zero multiply operand,
// illegal code) complete directly from IDLE.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   valid_i_mdc         request valid          ready_o_mdc      accept (IDLE)
//   mduop_i_mdc[3:0]    operation code         wordop_i_mdc     32-bit W form
//   op1_i_mdc, op2_i_mdc  rs1/dividend, rs2/divisor
//   flush_i_mdc         abort, back to IDLE without a result
//   out_valid_o_mdc     result valid           out_ready_i_mdc  result taken
//   result_o_mdc        registered result      busy_o_mdc       state != IDLE
//
// state | meaning
// IDLE  | waiting for a request, ready_o_mdc high
// MUL   | shift-add multiply iterations
// DIV   | restoring divide iterations
// DONE  | result held until out_ready_i_mdc
module ysyx_22040895_mdc #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i_mdc,
   output logic            ready_o_mdc,
   input  logic [3:0]      mduop_i_mdc,
   input  logic            wordop_i_mdc,
   input  logic [XLEN-1:0] op1_i_mdc,
   input  logic [XLEN-1:0] op2_i_mdc,
   input  logic            flush_i_mdc,
   output logic            out_valid_o_mdc,
   input  logic            out_ready_i_mdc,
   output logic [XLEN-1:0] result_o_mdc,
   output logic            busy_o_mdc
);
   localparam int HALF = XLEN / 2;
   localparam logic [6:0] N_FULL = 7'(XLEN);
   localparam logic [6:0] N_WORD = 7'(HALF);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t              state;
   logic [6:0]          cnt;
   logic [2*XLEN-1:0]   acc;      // MUL: {product hi, multiplier}; DIV: {remainder, quotient}
   logic [XLEN-1:0]     opb;      // multiplicand or divisor magnitude
   logic                neg_q, hi_q, word_q;
   logic                out_valid_q;
   logic [XLEN-1:0]     result_q;

   function automatic logic [XLEN-1:0] wext(input logic [HALF-1:0] v);
      return {{HALF{v[HALF-1]}}, v};
   endfunction

   // request decode
   logic is_mul, is_div, sgn1, sgn2, sel_hi, legal;
   always_comb begin
      is_mul = 1'b0;
      is_div = 1'b0;
      sgn1   = 1'b0;
      sgn2   = 1'b0;
      sel_hi = 1'b0;
      case (mduop_i_mdc)
         4'b0001: begin is_mul = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         4'b0010: begin is_mul = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; sel_hi = 1'b1; end
         4'b0011: begin is_mul = 1'b1; sgn1 = 1'b1; sel_hi = 1'b1; end
         4'b0100: begin is_mul = 1'b1; sel_hi = 1'b1; end
         4'b0101: begin is_div = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         4'b0110: begin is_div = 1'b1; end
         4'b0111: begin is_div = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; sel_hi = 1'b1; end
         4'b1000: begin is_div = 1'b1; sel_hi = 1'b1; end
         default: ;
      endcase
      // mulh/mulhsu/mulhu have no W form
      legal = (is_mul || is_div) && !(wordop_i_mdc && is_mul && sel_hi);
   end

   // word forms that are signed (mulw/divw/remw) have sgn1 == sgn2
   logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, min_val, fast_raw, fast_val;
   logic            neg_a, neg_b, neg_res, ovf, fast;
   always_comb begin
      if (wordop_i_mdc) begin
         ext_a   = sgn1 ? wext(op1_i_mdc[HALF-1:0]) : {{HALF{1'b0}}, op1_i_mdc[HALF-1:0]};
         ext_b   = sgn1 ? wext(op2_i_mdc[HALF-1:0]) : {{HALF{1'b0}}, op2_i_mdc[HALF-1:0]};
         min_val = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
      end else begin
         ext_a   = op1_i_mdc;
         ext_b   = op2_i_mdc;
         min_val = {1'b1, {(XLEN-1){1'b0}}};
      end
      neg_a   = sgn1 & ext_a[XLEN-1];
      neg_b   = sgn2 & ext_b[XLEN-1];
      mag_a   = neg_a ? -ext_a : ext_a;
      mag_b   = neg_b ? -ext_b : ext_b;
      neg_res = (is_div && sel_hi) ? neg_a : (neg_a ^ neg_b);
      ovf     = is_div && sgn1 && (ext_a == min_val) && (&ext_b);
      fast    = !legal
                || (is_mul && (ext_a == '0 || ext_b == '0))
                || (is_div && (ext_b == '0 || ovf));
      if (!legal || is_mul)
         fast_raw = '0;
      else if (ext_b == '0)
         fast_raw = sel_hi ? ext_a : '1;
      else
         fast_raw = sel_hi ? '0 : ext_a;
      fast_val = wordop_i_mdc ? wext(fast_raw[HALF-1:0]) : fast_raw;
   end

   // one iteration of each datapath
   logic [XLEN:0]     mul_sum, div_sh;
   logic [XLEN-1:0]   div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] mul_nxt, div_nxt, mul_fin;
   logic [XLEN-1:0]   div_pick, div_fin, done_val;
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      mul_nxt  = {mul_sum, acc[XLEN-1:1]};
      div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_ge   = div_sh >= {1'b0, opb};
      // difference is below the divisor whenever it is kept, so XLEN bits suffice
      div_diff = div_sh[XLEN-1:0] - opb;
      div_nxt  = {div_ge ? div_diff : div_sh[XLEN-1:0], acc[XLEN-2:0], div_ge};
      mul_fin  = neg_q ? -mul_nxt : mul_nxt;
      div_pick = hi_q ? div_nxt[2*XLEN-1:XLEN] : div_nxt[XLEN-1:0];
      div_fin  = neg_q ? -div_pick : div_pick;
      // a word multiply runs HALF steps, leaving its product at bit HALF upward
      if (state == MUL)
         done_val = word_q ? wext(mul_fin[XLEN-1:HALF])
                           : (hi_q ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0]);
      else
         done_val = word_q ? wext(div_fin[HALF-1:0]) : div_fin;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         opb         <= '0;
         neg_q       <= 1'b0;
         hi_q        <= 1'b0;
         word_q      <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else if (flush_i_mdc) begin
         state       <= IDLE;
         cnt         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (valid_i_mdc) begin
               word_q <= wordop_i_mdc;
               hi_q   <= sel_hi;
               neg_q  <= neg_res;
               if (fast) begin
                  state       <= DONE;
                  result_q    <= fast_val;
                  out_valid_q <= 1'b1;
               end else if (is_mul) begin
                  state <= MUL;
                  acc   <= {{XLEN{1'b0}}, mag_b};
                  opb   <= mag_a;
                  cnt   <= wordop_i_mdc ? N_WORD : N_FULL;
               end else begin
                  state <= DIV;
                  // word dividends start at the top so the first HALF shifts consume them
                  acc   <= {{XLEN{1'b0}},
                            wordop_i_mdc ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a};
                  opb   <= mag_b;
                  cnt   <= wordop_i_mdc ? N_WORD : N_FULL;
               end
            end
            MUL, DIV: begin
               acc <= (state == MUL) ? mul_nxt : div_nxt;
               cnt <= cnt - 7'd1;
               if (cnt == 7'd1) begin
                  state       <= DONE;
                  result_q    <= done_val;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: if (out_ready_i_mdc) begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ready_o_mdc     = (state == IDLE);
   assign busy_o_mdc      = (state != IDLE);
   assign out_valid_o_mdc = out_valid_q;
   assign result_o_mdc    = result_q;

endmodule

// File: tb/tb_ysyx_22040895_mdc.sv
// Testbench for ysyx_22040895_mdc: directed cases plus random ops compared
// against an arithmetic reference model of the RISC-V M-extension rules.
module tb_ysyx_22040895_mdc;
   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i_mdc;
   logic        ready_o_mdc;
   logic [3:0]  mduop_i_mdc;
   logic        wordop_i_mdc;
   logic [63:0] op1_i_mdc, op2_i_mdc;
   logic        flush_i_mdc;
   logic        out_valid_o_mdc;
   logic        out_ready_i_mdc;
   logic [63:0] result_o_mdc;
   logic        busy_o_mdc;

   int errors = 0;
   int checks = 0;

   ysyx_22040895_mdc #(.XLEN(64)) dut (
      .clk(clk), .rst(rst),
      .valid_i_mdc(valid_i_mdc), .ready_o_mdc(ready_o_mdc),
      .mduop_i_mdc(mduop_i_mdc), .wordop_i_mdc(wordop_i_mdc),
      .op1_i_mdc(op1_i_mdc), .op2_i_mdc(op2_i_mdc),
      .flush_i_mdc(flush_i_mdc),
      .out_valid_o_mdc(out_valid_o_mdc), .out_ready_i_mdc(out_ready_i_mdc),
      .result_o_mdc(result_o_mdc), .busy_o_mdc(busy_o_mdc)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension semantics in plain arithmetic
   function automatic logic [63:0] ref_model(input logic [3:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
      logic signed [63:0]  sa, sb;
      logic signed [31:0]  sa32, sb32;
      logic [31:0]         ua32, ub32, r32;
      logic [127:0]        p;
      logic                ovf64, ovf32;
      sa = a; sb = b;
      ua32 = a[31:0]; ub32 = b[31:0];
      sa32 = ua32; sb32 = ub32;
      ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
      ovf32 = (ua32 == 32'h8000_0000) && (ub32 == 32'hFFFF_FFFF);
      r32 = '0;
      if (w) begin
         case (op)
            4'd1: r32 = ua32 * ub32;
            4'd5: r32 = (ub32 == 0) ? 32'hFFFF_FFFF : (ovf32 ? ua32 : 32'(sa32 / sb32));
            4'd6: r32 = (ub32 == 0) ? 32'hFFFF_FFFF : ua32 / ub32;
            4'd7: r32 = (ub32 == 0) ? ua32 : (ovf32 ? 32'h0 : 32'(sa32 % sb32));
            4'd8: r32 = (ub32 == 0) ? ua32 : ua32 % ub32;
            default: return 64'h0;
         endcase
         return {{32{r32[31]}}, r32};
      end
      case (op)
         4'd1: return a * b;
         4'd2: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
         4'd3: begin p = {{64{a[63]}}, a} * {64'h0, b};       return p[127:64]; end
         4'd4: begin p = {64'h0, a} * {64'h0, b};             return p[127:64]; end
         4'd5: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf64 ? a : 64'(sa / sb));
         4'd6: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
         4'd7: return (b == 0) ? a : (ovf64 ? 64'h0 : 64'(sa % sb));
         4'd8: return (b == 0) ? a : a % b;
         default: return 64'h0;
      endcase
   endfunction

   // cycles after accept until out_valid is seen: 0 for the direct cases, else N
   function automatic int exp_lat(input logic [3:0] op, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      logic za, zb, ovf;
      if (op < 4'd1 || op > 4'd8 || (w && op >= 4'd2 && op <= 4'd4)) return 0;
      za  = w ? (a[31:0] == 0) : (a == 0);
      zb  = w ? (b[31:0] == 0) : (b == 0);
      ovf = (op == 4'd5 || op == 4'd7) &&
            (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
               : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
      if (op <= 4'd4 && (za || zb)) return 0;
      if (op >= 4'd5 && (zb || ovf)) return 0;
      return w ? 32 : 64;
   endfunction

   // present one request for a single edge; called at a negedge
   task automatic start_op(input logic [3:0] op, input logic w,
                           input logic [63:0] a, input logic [63:0] b);
      int k;
      k = 0;
      while (!ready_o_mdc && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!ready_o_mdc) check_val("ready_wait", 64'(ready_o_mdc), 64'h1);
      valid_i_mdc  = 1'b1;
      mduop_i_mdc  = op;
      wordop_i_mdc = w;
      op1_i_mdc    = a;
      op2_i_mdc    = b;
      @(negedge clk);
      // junk on the inputs while busy must not matter
      valid_i_mdc  = 1'b0;
      mduop_i_mdc  = 4'($urandom_range(0, 15));
      wordop_i_mdc = 1'($urandom_range(0, 1));
      op1_i_mdc    = {$urandom, $urandom};
      op2_i_mdc    = {$urandom, $urandom};
   endtask

   task automatic run_op(input logic [3:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input int hold);
      logic [63:0] exp_r;
      int          exp_j, j, busy_n;
      string       tag;
      exp_r  = ref_model(op, w, a, b);
      exp_j  = exp_lat(op, w, a, b);
      tag    = $sformatf("op%0d w%0d a=%h b=%h", op, w, a, b);
      start_op(op, w, a, b);
      busy_n = 0;
      j      = 0;
      while (!out_valid_o_mdc && j < 80) begin
         if (busy_o_mdc) busy_n++;
         @(negedge clk);
         j++;
      end
      check_val({"latency ", tag}, 64'(j), 64'(exp_j));
      if (!out_valid_o_mdc) begin
         flush_i_mdc = 1'b1;
         @(negedge clk);
         flush_i_mdc = 1'b0;
         return;
      end
      busy_n++;
      check_val({"result ", tag}, result_o_mdc, exp_r);
      check_val({"ready_in_done ", tag}, 64'(ready_o_mdc), 64'h0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (busy_o_mdc) busy_n++;
         check_val($sformatf("hold_valid %0d", h), 64'(out_valid_o_mdc), 64'h1);
         check_val($sformatf("hold_result %0d", h), result_o_mdc, exp_r);
      end
      out_ready_i_mdc = 1'b1;
      @(negedge clk);
      out_ready_i_mdc = 1'b0;
      check_val({"ready_after ", tag}, 64'(ready_o_mdc), 64'h1);
      check_val({"valid_after ", tag}, 64'(out_valid_o_mdc), 64'h0);
      check_val({"busy_cycles ", tag}, 64'(busy_n), 64'(exp_j + 1 + hold));
   endtask

   task automatic expect_idle_quiet(input string tag, input int cycles);
      int v;
      v = 0;
      check_val({tag, " ready"}, 64'(ready_o_mdc), 64'h1);
      check_val({tag, " busy"}, 64'(busy_o_mdc), 64'h0);
      for (int k = 0; k < cycles; k++) begin
         if (out_valid_o_mdc) v++;
         @(negedge clk);
      end
      check_val({tag, " valid_count"}, 64'(v), 64'h0);
   endtask

   function automatic logic [63:0] rand_operand();
      case ($urandom_range(0, 9))
         0: return 64'h0;
         1: return 64'hFFFF_FFFF_FFFF_FFFF;
         2: return 64'h8000_0000_0000_0000;
         3: return 64'hFFFF_FFFF_8000_0000;
         4: return 64'($urandom_range(1, 20));
         5: return {32'h0, $urandom};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      logic [3:0] rop;
      rst             = 1'b0;
      valid_i_mdc     = 1'b0;
      mduop_i_mdc     = '0;
      wordop_i_mdc    = 1'b0;
      op1_i_mdc       = '0;
      op2_i_mdc       = '0;
      flush_i_mdc     = 1'b0;
      out_ready_i_mdc = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset ready", 64'(ready_o_mdc), 64'h1);
      check_val("reset busy", 64'(busy_o_mdc), 64'h0);
      check_val("reset valid", 64'(out_valid_o_mdc), 64'h0);
      check_val("reset result", result_o_mdc, 64'h0);
      rst = 1'b1;
      @(negedge clk);

      run_op(4'd1, 1'b0, 64'd7, -64'sd3, 0);
      run_op(4'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op(4'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op(4'd3, 1'b0, -64'sd5, 64'd3, 0);
      run_op(4'd5, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op(4'd7, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op(4'd5, 1'b0, -64'sd7, 64'd2, 0);
      run_op(4'd7, 1'b0, -64'sd7, 64'd2, 0);
      run_op(4'd6, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
      run_op(4'd8, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
      run_op(4'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 0);
      run_op(4'd5, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op(4'd2, 1'b1, 64'd9, 64'd9, 0);
      run_op(4'd0, 1'b0, 64'd9, 64'd9, 0);
      run_op(4'd12, 1'b0, 64'd9, 64'd9, 0);
      run_op(4'd1, 1'b1, 64'h0000_0000_1234_5678, 64'd9, 5);

      // reset in the middle of a multiply
      start_op(4'd1, 1'b0, 64'd7, 64'd3);
      repeat (20) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check_val("rst_mid valid", 64'(out_valid_o_mdc), 64'h0);
      check_val("rst_mid result", result_o_mdc, 64'h0);
      expect_idle_quiet("rst_mid", 70);

      // flush in the middle of a divide
      start_op(4'd5, 1'b0, -64'sd7, 64'd2);
      repeat (9) @(negedge clk);
      flush_i_mdc = 1'b1;
      @(negedge clk);
      flush_i_mdc = 1'b0;
      expect_idle_quiet("flush_div", 70);

      // a request presented with flush is not taken
      valid_i_mdc = 1'b1;
      mduop_i_mdc = 4'd5;
      op1_i_mdc   = 64'd100;
      op2_i_mdc   = 64'd7;
      flush_i_mdc = 1'b1;
      @(negedge clk);
      valid_i_mdc = 1'b0;
      flush_i_mdc = 1'b0;
      expect_idle_quiet("flush_req", 70);

      // flush while holding a result
      start_op(4'd6, 1'b0, 64'd5, 64'd0);
      check_val("flush_done pre_valid", 64'(out_valid_o_mdc), 64'h1);
      flush_i_mdc = 1'b1;
      @(negedge clk);
      flush_i_mdc = 1'b0;
      check_val("flush_done valid", 64'(out_valid_o_mdc), 64'h0);
      check_val("flush_done ready", 64'(ready_o_mdc), 64'h1);

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0)
            rop = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
         else
            rop = 4'($urandom_range(1, 8));
         run_op(rop, 1'($urandom_range(0, 1)), rand_operand(), rand_operand(),
                int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22040895_mdc.md
# ysyx_22040895_mdc

Multi-cycle multiply/divide controller for the RV64 execute stage. It accepts one M-extension operation at a time over a valid/ready handshake and runs it as an iterative radix-2 shift-add multiply or restoring divide. It holds `busy_o_mdc` high so the pipeline stalls until the result is delivered over an output valid/ready handshake. It replaces the single-cycle combinational multiply/divide path behind the EXU result mux.

## Interface
- `XLEN`, 64: datapath width; word operations use `XLEN/2`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `valid_i_mdc` in 1: request valid.
- `ready_o_mdc` out 1: controller can accept a request (state IDLE).
- `mduop_i_mdc` in 4: 0001 mul, 0010 mulh, 0011 mulhsu, 0100 mulhu, 0101 div, 0110 divu, 0111 rem, 1000 remu; all other codes are illegal.
- `wordop_i_mdc` in 1: 32-bit W variant.
- `op1_i_mdc` in XLEN: rs1 / dividend.
- `op2_i_mdc` in XLEN: rs2 / divisor.
- `flush_i_mdc` in 1: abort the current operation.
- `out_valid_o_mdc` out 1: result valid.
- `out_ready_i_mdc` in 1: consumer accepts the result.
- `result_o_mdc` out XLEN: result.
- `busy_o_mdc` out 1: high whenever the state is not IDLE.

## Operation
- States and transitions:
  - IDLE: on accept (`valid_i_mdc && ready_o_mdc`), go to MUL, DIV, or DONE (fast path).
  - MUL / DIV: after N iterations, go to DONE.
  - DONE: on `out_ready_i_mdc`, go to IDLE.
- Iteration count N = 64, or 32 when `wordop_i_mdc` = 1. A 7-bit down-counter tracks iterations; its reset value is 0.
- Operand latch on accept:
  - Signed ops (mul family signed per RISC-V; div, rem, divw, remw, mulw): operate on magnitudes plus a result-sign flag.
  - Word ops: operands are first sign-extended (signed ops) or zero-extended (divuw, remuw) from bit 31.
  - mulhsu: op1 is signed, op2 is unsigned.
- MUL: a 2·XLEN product register. Each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half, then shift right by 1.
  - In DONE, negate the product if the sign flag is set.
  - mul and mulw take the low half. mulh, mulhsu, mulhu take the high half.
- DIV: each cycle, shift the {remainder, quotient} pair left by 1 and trial-subtract the divisor. If the difference is non-negative, keep it and set quotient bit 0.
  - Quotient sign = op1 sign XOR op2 sign.
  - Remainder sign = op1 sign.
- Word ops: result = sign-extend of bit 31 of the 32-bit result, for both signed and unsigned W forms.
- Fast paths (IDLE → DONE directly):
  - Divisor = 0: quotient = all ones; remainder = dividend (after word extension).
  - Signed overflow (div/rem of the most-negative value by −1, at 64- or 32-bit width): quotient = dividend; remainder = 0.
  - Either multiply operand = 0: result = 0.
  - Illegal code, or wordop with mulh/mulhsu/mulhu/divu-class codes outside {mul, div, divu, rem, remu}: result = 0.
- `result_o_mdc` is registered and stays stable throughout DONE.
- Flush: in any state, `flush_i_mdc` forces IDLE on the next edge. No `out_valid_o_mdc` is produced. A request presented together with flush in IDLE is not accepted.
- Reset mid-operation behaves like flush and also zeroes all registers.

## Timing
- Reset values (the cycle after `rst` = 0): state IDLE, `ready_o_mdc` = 1, `busy_o_mdc` = 0, `out_valid_o_mdc` = 0, `result_o_mdc` = 0.
- Accept at edge E0. `out_valid_o_mdc` first goes high N+1 cycles after E0: 65 cycles for 64-bit, 33 cycles for word.
- Fast path: `out_valid_o_mdc` goes high 1 cycle after E0.
- `out_valid_o_mdc` holds until the edge where `out_ready_i_mdc` = 1. `ready_o_mdc` rises the following cycle, giving no back-to-back overlap.
- `ready_o_mdc` = 0 and `busy_o_mdc` = 1 in MUL, DIV, and DONE.
- `ready_o_mdc` and `busy_o_mdc` are combinational from state only. Inputs are ignored outside IDLE.

## Test plan
- mul, op1 = 7, op2 = −3 → result 0xFFFF_FFFF_FFFF_FFEB. `out_valid_o_mdc` at E0+65. `busy_o_mdc` = 1 for 65 cycles.
- mulhu, op1 = op2 = 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. mulh with the same operands → 0.
- divw, op1 = 0x0000_0000_8000_0000, op2 = −1 → fast path 0xFFFF_FFFF_8000_0000 at E0+1. remw with the same operands → 0.
- div, op1 = −7, op2 = 2 → −3. rem → −1. divu, op2 = 0 → 0xFFFF_FFFF_FFFF_FFFF at E0+1. remu, op2 = 0 → op1.
- divuw, op1 = 0xFFFF_FFFF_FFFF_FFF0, op2 = 3 → 0x0000_0000_5555_5550 (bit 31 = 0), delivered at E0+33.
- Start div, assert `flush_i_mdc` at E0+10 → IDLE at E0+11 with no `out_valid_o_mdc`. Repeat with `rst` = 0 mid-MUL → all outputs at reset values. Hold `out_ready_i_mdc` = 0 for 5 cycles in DONE → result held stable, then `ready_o_mdc` rises one cycle after the handshake.
